// File: rtl/pixel_ram_pkg.sv
// rtl/pixel_ram_pkg.sv - shared state type and default sizes for the pixel RAM
package pixel_ram_pkg;

   typedef enum logic [1:0] {
      CLEAR     = 2'd0,
      READY     = 2'd1,
      IDLE_HOLD = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 64;

endpackage

// File: rtl/pixel_ram_core.sv
// rtl/pixel_ram_core.sv - storage array, one write port and one registered read port
// No reset: contents are zeroed by the controller's clear sequence.
module pixel_ram_core #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Read-before-write: a same-address read returns the word stored before this edge.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/pixel_ram.sv
// rtl/pixel_ram.sv - pixel RAM with power-up/on-demand clear, range checking and read port
// Optional macro PIXEL_RAM_BYPASS_EN: same-address read-during-write returns the new data.
module pixel_ram
   import pixel_ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init_start,
   output logic              busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              addr_err
);

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              rd_zero;
   logic [DATA_W-1:0] core_q;

   logic              is_ready, in_clear;
   logic              wr_in_range, rd_in_range;
   logic              wr_take, wr_ok, wr_bad;
   logic              rd_acc, rd_bad;
   logic              core_we, core_re;
   logic [ADDR_W-1:0] core_waddr;
   logic [DATA_W-1:0] core_wdata;

   assign is_ready    = (state == READY);
   assign in_clear    = (state == CLEAR);
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

   // A write coinciding with init_start is dropped, not accepted.
   assign wr_take = is_ready & wr_en & ~init_start;
   assign wr_ok   = wr_take & wr_in_range;
   assign wr_bad  = wr_take & ~wr_in_range;
   assign rd_acc  = is_ready & rd_en;
   assign rd_bad  = rd_acc & ~rd_in_range;

   assign core_we    = in_clear | wr_ok;
   assign core_waddr = in_clear ? clr_cnt : wr_addr;
   assign core_wdata = in_clear ? '0 : wr_data;
   assign core_re    = rd_acc & rd_in_range;

   pixel_ram_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk   (clk),
      .we    (core_we),
      .waddr (core_waddr),
      .wdata (core_wdata),
      .re    (core_re),
      .raddr (rd_addr),
      .rdata (core_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CLEAR;
         clr_cnt  <= '0;
         busy     <= 1'b1;
         rd_valid <= 1'b0;
         rd_zero  <= 1'b1;
         addr_err <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) rd_zero <= ~rd_in_range;
         if (wr_bad | rd_bad) addr_err <= 1'b1;
         case (state)
            CLEAR: begin
               if (clr_cnt == LAST) begin
                  clr_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= READY;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            READY: begin
               if (init_start) begin
                  clr_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= wr_en ? IDLE_HOLD : CLEAR;
               end
            end
            IDLE_HOLD: begin
               state <= CLEAR;
            end
            default: begin
               state <= CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

`ifdef PIXEL_RAM_BYPASS_EN
   logic              byp_hit, rd_byp;
   logic [DATA_W-1:0] byp_data;

   assign byp_hit = wr_ok & rd_acc & rd_in_range & (wr_addr == rd_addr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_byp   <= 1'b0;
         byp_data <= '0;
      end else if (rd_acc) begin
         rd_byp <= byp_hit;
         if (byp_hit) byp_data <= wr_data;
      end
   end

   assign rd_data = rd_zero ? '0 : (rd_byp ? byp_data : core_q);
`else
   assign rd_data = rd_zero ? '0 : core_q;
`endif

endmodule

// File: tb/tb_pixel_ram.sv
// tb/tb_pixel_ram.sv - directed vector bench for pixel_ram (default and DEPTH=48 instances)
module tb_pixel_ram;

   logic       clk = 1'b0;
   logic       reset;
   logic       init_start, wr_en, rd_en;
   logic [5:0] wr_addr, rd_addr;
   logic [7:0] wr_data, rd_data;
   logic       busy, rd_valid, addr_err;

   logic       b_init_start, b_wr_en, b_rd_en;
   logic [5:0] b_wr_addr, b_rd_addr;
   logic [7:0] b_wr_data, b_rd_data;
   logic       b_busy, b_rd_valid, b_addr_err;

   int checks = 0;
   int errors = 0;

`ifdef PIXEL_RAM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   pixel_ram dut (
      .clk(clk), .reset(reset), .init_start(init_start), .busy(busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .addr_err(addr_err)
   );

   pixel_ram #(.DEPTH(48)) dut48 (
      .clk(clk), .reset(reset), .init_start(b_init_start), .busy(b_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .rd_valid(b_rd_valid), .addr_err(b_addr_err)
   );

   typedef struct {
      logic       we;
      logic [5:0] wa;
      logic [7:0] wd;
      logic       re;
      logic [5:0] ra;
      logic       exp_valid;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int n, n48, viol, bad;

      vecs[0]  = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd5,  1'b1, 8'h00};
      vecs[1]  = '{1'b1, 6'd10, 8'hA5, 1'b0, 6'd0,  1'b0, 8'h00};
      vecs[2]  = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd10, 1'b1, 8'hA5};
      vecs[3]  = '{1'b0, 6'd0,  8'h00, 1'b0, 6'd0,  1'b0, 8'hA5};
      vecs[4]  = '{1'b1, 6'd5,  8'h11, 1'b0, 6'd0,  1'b0, 8'hA5};
      vecs[5]  = '{1'b1, 6'd5,  8'h3C, 1'b1, 6'd5,  1'b1, BYP ? 8'h3C : 8'h11};
      vecs[6]  = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd5,  1'b1, 8'h3C};
      vecs[7]  = '{1'b1, 6'd63, 8'h7E, 1'b1, 6'd10, 1'b1, 8'hA5};
      vecs[8]  = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd63, 1'b1, 8'h7E};
      vecs[9]  = '{1'b1, 6'd0,  8'h01, 1'b1, 6'd0,  1'b1, BYP ? 8'h01 : 8'h00};
      vecs[10] = '{1'b1, 6'd20, 8'hC3, 1'b1, 6'd63, 1'b1, 8'h7E};
      vecs[11] = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd20, 1'b1, 8'hC3};

      reset = 1'b1;
      init_start = 0; wr_en = 0; rd_en = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
      b_init_start = 0; b_wr_en = 0; b_rd_en = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0;
      step(); step();
      check("reset_busy", busy, 1);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_addr_err", addr_err, 0);
      check("reset48_addr_err", b_addr_err, 0);

      // Power-up clear with accesses attempted throughout
      reset = 1'b0;
      wr_en = 1; wr_addr = 6'd5; wr_data = 8'hEE; rd_en = 1; rd_addr = 6'd7;
      b_wr_en = 1; b_wr_addr = 6'd50; b_wr_data = 8'hEE; b_rd_en = 1; b_rd_addr = 6'd50;
      n = 0; n48 = 0; viol = 0;
      while ((busy || b_busy) && n < 200) begin
         step();
         n++;
         if (rd_valid || b_rd_valid) viol++;
         if (!b_busy && n48 == 0) n48 = n;
         if (n == 46) begin b_wr_en = 0; b_rd_en = 0; end
         if (n == 63) begin wr_en = 0; rd_en = 0; end
      end
      wr_en = 0; rd_en = 0;
      check("clear_cycles_64", n, 64);
      check("clear_cycles_48", n48, 48);
      check("clear_rd_valid_quiet", viol, 0);
      check("clear_addr_err48", b_addr_err, 0);

      for (int i = 0; i < 12; i++) begin
         wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
         rd_en = vecs[i].re; rd_addr = vecs[i].ra;
         step();
         check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].exp_valid);
         check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
      end
      wr_en = 0; rd_en = 0;
      check("vec_addr_err", addr_err, 0);

      // Out-of-range accesses on the 48-word instance
      b_wr_en = 1; b_wr_addr = 6'd50; b_wr_data = 8'h99;
      step();
      b_wr_en = 0;
      check("oor_wr_addr_err", b_addr_err, 1);
      b_rd_en = 1; b_rd_addr = 6'd50;
      step();
      check("oor_rd_valid", b_rd_valid, 1);
      check("oor_rd_data", b_rd_data, 0);
      b_rd_addr = 6'd2;
      step();
      check("oor_no_alias", b_rd_data, 0);
      b_rd_en = 0; b_wr_en = 1; b_wr_addr = 6'd47; b_wr_data = 8'h5A;
      step();
      b_wr_en = 0; b_rd_en = 1; b_rd_addr = 6'd47;
      step();
      b_rd_en = 0;
      check("d48_last_word", b_rd_data, 8'h5A);
      repeat (5) step();
      check("oor_sticky", b_addr_err, 1);

      // init_start together with wr_en goes through IDLE_HOLD
      init_start = 1; wr_en = 1; wr_addr = 6'd10; wr_data = 8'h55;
      step();
      init_start = 0; wr_en = 0;
      n = 1;
      while (busy && n < 200) begin step(); n++; end
      check("idle_hold_cycles", n, 66);
      rd_en = 1; rd_addr = 6'd10;
      step();
      rd_en = 0;
      check("idle_hold_drop", rd_data, 0);

      // Fill with 0xFF, clear, then reset mid-clear
      for (int i = 0; i < 64; i++) begin
         wr_en = 1; wr_addr = 6'(i); wr_data = 8'hFF;
         step();
      end
      wr_en = 0; rd_en = 1; rd_addr = 6'd30;
      step();
      rd_en = 0;
      check("fill_ff", rd_data, 8'hFF);
      init_start = 1;
      step();
      init_start = 0;
      check("init_busy", busy, 1);
      repeat (20) step();
      reset = 1;
      #1;
      check("midclear_reset_rd_data", rd_data, 0);
      check("midclear_reset_busy", busy, 1);
      step();
      reset = 0;
      n = 0;
      while (busy && n < 200) begin step(); n++; end
      check("restart_clear_cycles", n, 64);
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         rd_en = 1; rd_addr = 6'(i);
         step();
         if (rd_valid !== 1'b1 || rd_data !== 8'h00) bad++;
      end
      rd_en = 0;
      check("all_words_zero", bad, 0);
      check("final_addr_err", addr_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
